// File: rtl/linebuf_feed.sv
// Address/coordinate generator that streams one image, pixel by pixel, into a
// downstream 5x5 line-buffer window and flags the cycles holding a full window.
module linebuf_feed #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned AWIDTH    = 16,
  parameter int unsigned IMG_WIDTH = 12,
  parameter int unsigned FSIZE     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [7:0]        img_height,
  output logic              mem_en,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              win_valid,
  output logic [7:0]        win_row,
  output logic [7:0]        win_col,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] LAST_COL = 8'(IMG_WIDTH - 1);
  localparam logic [7:0] EDGE     = 8'(FSIZE - 1);

  // Elaboration guard: the window must fit in a line and pixels must have width.
  if (DWIDTH == 0 || FSIZE == 0 || FSIZE > IMG_WIDTH) begin : g_param_check
    $error("linebuf_feed: invalid DWIDTH/FSIZE/IMG_WIDTH combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [7:0]        r_height;
  logic [7:0]        r_row;
  logic [7:0]        r_col;
  logic              r_flush_cnt;
  logic              r_mem_en;
  logic [AWIDTH-1:0] r_mem_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_p1_vld;
  logic [7:0]        r_p1_row;
  logic [7:0]        r_p1_col;
  logic              r_win_valid;
  logic [7:0]        r_win_row;
  logic [7:0]        r_win_col;

  logic w_last_pix;
  logic w_win_ok;

  assign w_last_pix = (r_row == r_height - 8'd1) && (r_col == LAST_COL);
  assign w_win_ok   = (r_row >= EDGE) && (r_col >= EDGE);

  // Control FSM with registered memory-side and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_height    <= 8'd0;
      r_row       <= 8'd0;
      r_col       <= 8'd0;
      r_flush_cnt <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_height <= img_height;
            r_row    <= 8'd0;
            r_col    <= 8'd0;
            if (img_height != 8'd0) begin
              r_state    <= S_READ;
              r_mem_en   <= 1'b1;
              r_mem_addr <= base_addr;
              r_busy     <= 1'b1;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_READ: begin
          if (w_last_pix) begin
            r_state     <= S_FLUSH;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_flush_cnt <= 1'b0;
          end else begin
            r_mem_addr <= r_mem_addr + AWIDTH'(1);
            if (r_col == LAST_COL) begin
              r_col <= 8'd0;
              r_row <= r_row + 8'd1;
            end else begin
              r_col <= r_col + 8'd1;
            end
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_flush_cnt <= 1'b1;
          end
        end
        S_DONE: begin
          // An empty image enters DONE without the pulse armed; it pulses one slot later.
          if (r_done) begin
            r_state <= S_IDLE;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Two-stage coordinate pipeline aligned with memory latency plus buffer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_vld    <= 1'b0;
      r_p1_row    <= 8'd0;
      r_p1_col    <= 8'd0;
      r_win_valid <= 1'b0;
      r_win_row   <= 8'd0;
      r_win_col   <= 8'd0;
    end else begin
      r_p1_vld    <= r_mem_en && w_win_ok;
      r_p1_row    <= r_row;
      r_p1_col    <= r_col;
      r_win_valid <= r_p1_vld;
      r_win_row   <= r_p1_vld ? r_p1_row - EDGE : 8'd0;
      r_win_col   <= r_p1_vld ? r_p1_col - EDGE : 8'd0;
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_addr  = r_mem_addr;
  assign win_valid = r_win_valid;
  assign win_row   = r_win_row;
  assign win_col   = r_win_col;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_linebuf_feed.sv
// Scoreboard bench for linebuf_feed: expected reads/windows are queued at start
// and retired as the DUT produces them; a small window-buffer model checks contents.
module tb_linebuf_feed;

  localparam int unsigned AW   = 16;
  localparam int unsigned W    = 12;
  localparam int unsigned F    = 5;
  localparam int unsigned SR_L = (F - 1) * W + F;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [7:0]    img_height;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic          win_valid;
  logic [7:0]    win_row;
  logic [7:0]    win_col;
  logic          busy;
  logic          done;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   s_cyc    = 0;
  int   n_run    = 0;
  int   h_run    = 0;
  int   exp_done = 0;
  bit   active   = 0;
  bit   done_seen = 0;
  bit   pix_en   = 0;
  bit   first_win = 0;
  exp_t addr_q[$];
  exp_t win_q[$];

  logic       rd_vld;
  logic [7:0] rd_data;
  logic [7:0] sr [0:SR_L-1];

  linebuf_feed #(.DWIDTH(8), .AWIDTH(AW), .IMG_WIDTH(W), .FSIZE(F)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .img_height(img_height),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .win_valid (win_valid),
    .win_row   (win_row),
    .win_col   (win_col),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory holds memory[a] = a[7:0]; one-cycle read latency, then the window shift register.
  always @(posedge clk) begin
    rd_vld  <= mem_en;
    rd_data <= mem_addr[7:0];
    if (rd_vld) begin
      for (int i = SR_L - 1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= rd_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc - s_cyc);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({mem_en, mem_addr, win_valid, win_row, win_col, busy, done});
  endfunction

  // Output monitor: retires scoreboard entries as the DUT reports them.
  always @(negedge clk) begin
    if (active) begin
      int   rel;
      exp_t e;
      bit   exp_busy;
      rel      = cyc - s_cyc;
      exp_busy = (h_run != 0) && (rel >= 1) && (rel <= n_run + 2);
      chk("busy", 64'(busy), 64'(exp_busy));
      if (mem_en) begin
        if (addr_q.size() == 0) begin
          chk("extra_read", 64'(1), 64'(0));
        end else begin
          e = addr_q.pop_front();
          chk("rd_cycle", 64'(rel), 64'(e.cyc));
          chk("rd_addr", 64'(mem_addr), 64'(e.val));
        end
      end
      if (win_valid) begin
        if (win_q.size() == 0) begin
          chk("extra_window", 64'(1), 64'(0));
        end else begin
          e = win_q.pop_front();
          chk("win_cycle", 64'(rel), 64'(e.cyc));
          chk("win_rowcol", 64'({win_row, win_col}), 64'(e.val));
        end
        if (pix_en && first_win) begin
          chk("pixel0", 64'(sr[(F-1)*W + (F-1)]), 64'(8'h00));
          chk("pixel5", 64'(sr[(F-2)*W + (F-1)]), 64'(8'h0C));
          chk("pixel24", 64'(sr[0]), 64'(8'h34));
        end
        first_win = 0;
      end else begin
        chk("win_idle_rowcol", 64'({win_row, win_col}), 64'(0));
      end
      if (done) begin
        chk("done_cycle", 64'(rel), 64'(exp_done));
        done_seen = 1;
      end
    end
  end

  task automatic run_img(input logic [AW-1:0] base, input logic [7:0] h,
                         input bit restart, input bit pix);
    int   n;
    int   row;
    int   col;
    exp_t e;
    n = int'(W) * int'(h);
    addr_q.delete();
    win_q.delete();
    for (int k = 0; k < n; k++) begin
      row   = k / int'(W);
      col   = k % int'(W);
      e.cyc = 1 + k;
      e.val = 32'(AW'(base + AW'(k)));
      addr_q.push_back(e);
      if (row >= int'(F) - 1 && col >= int'(F) - 1) begin
        e.cyc = k + 3;
        e.val = 32'({8'(row - int'(F) + 1), 8'(col - int'(F) + 1)});
        win_q.push_back(e);
      end
    end
    exp_done  = (h == 8'd0) ? 2 : n + 3;
    n_run     = n;
    h_run     = int'(h);
    done_seen = 0;
    first_win = 1;
    pix_en    = pix;
    @(negedge clk);
    s_cyc      = cyc;
    active     = 1;
    start      = 1'b1;
    base_addr  = base;
    img_height = h;
    @(negedge clk);
    start      = 1'b0;
    base_addr  = ~base;
    img_height = 8'd3;
    if (restart) begin
      while (cyc < s_cyc + 10) @(negedge clk);
      start      = 1'b1;
      base_addr  = 16'h0000;
      img_height = 8'd1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int t = 0; t < n + 40 && !done_seen; t++) @(posedge clk);
    chk("done_seen", 64'(done_seen), 64'(1));
    repeat (3) @(negedge clk);
    active = 0;
    chk("reads_left", 64'(addr_q.size()), 64'(0));
    chk("windows_left", 64'(win_q.size()), 64'(0));
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    s_cyc      = cyc;
    start      = 1'b1;
    base_addr  = 16'h0100;
    img_height = 8'd12;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s_cyc + 30) @(negedge clk);
    chk("pre_rst_mem_en", 64'(mem_en), 64'(1));
    rst = 1'b1;
    #1;
    chk("rst_async_outs", all_outs(), 64'(0));
    @(negedge clk);
    chk("rst_next_outs", all_outs(), 64'(0));
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("rst_quiet", 64'({mem_en, win_valid, busy, done}), 64'(0));
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    img_height = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_img(16'h0100, 8'd12, 1'b0, 1'b1);
    run_img(16'h0100, 8'd4,  1'b0, 1'b0);
    run_img(16'h0300, 8'd0,  1'b0, 1'b0);
    run_img(16'h0200, 8'd12, 1'b1, 1'b0);
    run_img(16'hFFF0, 8'd5,  1'b0, 1'b0);
    reset_mid_run();
    run_img(16'h0040, 8'd6,  1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/linebuf_feed.md
LINEBUF_FEED -- requirements
Module: linebuf_feed

Interface
REQ-001 SHALL: parameter DWIDTH, from parameters.vh, data width of the pixel stream (not used internally except for documentation consistency).
REQ-002 SHALL: parameter AWIDTH, default 16, memory address width.
REQ-003 SHALL: parameter IMG_WIDTH, default 12, pixels per image line; it equals the line length of the downstream 5x5 shift-register window.
REQ-004 SHALL: parameter FSIZE, default 5, window edge length.
REQ-005 SHALL: clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL: rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL: start  input  1  single-cycle request to stream one image.
REQ-008 SHALL: base_addr  input  AWIDTH  address of pixel (0,0), sampled with start.
REQ-009 SHALL: img_height  input  8  number of image lines, sampled with start.
REQ-010 SHALL: mem_en  output  1  memory read enable, one pixel per asserted cycle.
REQ-011 SHALL: mem_addr  output  AWIDTH  read address; read_data returns exactly 1 cycle later into the window buffer.
REQ-012 SHALL: win_valid  output  1  window outputs (pixel0..pixel24) hold a complete 5x5 window this cycle.
REQ-013 SHALL: win_row, win_col  output  8 each  top-left coordinate of the valid window.
REQ-014 SHALL: busy  output  1  high from first read cycle through last pipeline cycle.
REQ-015 SHALL: done  output  1  one-cycle pulse after the final window slot.

Function
REQ-016 SHALL: FSM states IDLE, READ, FLUSH, DONE; IDLE->READ on start with img_height!=0; IDLE->DONE on start with img_height==0.
REQ-017 SHALL: with start sampled at the edge ending cycle 0, READ occupies cycles 1..N, N=IMG_WIDTH*img_height, mem_en=1, mem_addr=base_addr+k in cycle 1+k.
REQ-018 SHALL: row/col counters track pixel k; col wraps IMG_WIDTH-1 -> 0 and increments row; address arithmetic wraps modulo 2^AWIDTH.
REQ-019 SHALL: READ->FLUSH after k=N-1; FLUSH lasts 2 cycles (memory latency + buffer register); FLUSH->DONE; DONE->IDLE after 1 cycle with done=1.
REQ-020 SHALL: (en,row,col) of each read pass through a 2-stage pipeline; win_valid asserted in cycle k+3 iff row(k)>=FSIZE-1 and col(k)>=FSIZE-1.
REQ-021 SHALL: win_row=row(k)-(FSIZE-1), win_col=col(k)-(FSIZE-1) when win_valid; 0 otherwise.
REQ-022 SHALL: windows straddling a line boundary (col(k)<FSIZE-1) never assert win_valid.
REQ-023 SHALL: img_height<FSIZE: all pixels read, win_valid never asserted, done still pulses.
REQ-024 SHALL: start while not IDLE ignored; base_addr/img_height changes after sampling have no effect.
REQ-025 SHALL: busy=1 in READ and FLUSH, 0 in IDLE and DONE; mem_en=0 outside READ.

Reset
REQ-026 SHALL: rst asserted at any time (including mid-READ) forces IDLE immediately; mem_en, mem_addr, win_valid, win_row, win_col, busy, done all 0; pipeline cleared.
REQ-027 SHALL: first start after rst deassertion is honoured normally; no residual win_valid from the aborted image.

Verification
REQ-028 SHALL: base_addr=0x0100, img_height=12 -> addresses 0x0100..0x018F in cycles 1..144, first win_valid cycle 55 (0,0), last cycle 146 (7,7), 64 windows total, done cycle 147.
REQ-029 SHALL: window contents check: memory[i]=i, img_height=12 -> at first win_valid pixel0=0x00, pixel24=0x34, pixel5=0x0C.
REQ-030 SHALL: img_height=4 -> 48 reads, zero win_valid, done cycle 51; img_height=0 -> no mem_en, done cycle 2.
REQ-031 SHALL: rst pulsed in cycle 30 of an img_height=12 run -> all outputs 0 next cycle, no further mem_en until new start.
REQ-032 SHALL: start re-pulsed in cycle 10 of a run -> ignored, address sequence and done timing unchanged.
REQ-033 SHALL: base_addr=0xFFF0, img_height=5 -> mem_addr wraps 0xFFFF->0x0000 at k=16, 8 windows at rows 0, cols 0..7.
